// File: rtl/sra_seq_ctrl.sv
// Sequencer in front of the external combinational AU: walks one AU operation per state
// to form sqrt(a^2+b^2) ~= max(x, x - x/8 + y/2) with x = max(|a|,|b|), y = min(|a|,|b|).
module sra_seq_ctrl #(
    parameter int MSB = 15
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [MSB:0] a_i,
    input  logic [MSB:0] b_i,
    output logic [MSB:0] au_in1_o,
    output logic [MSB:0] au_in2_o,
    output logic [1:0]   au_ctrl_o,
    input  logic [MSB:0] au_out_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [MSB:0] result_o,
    output logic         sat_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ABS_A, S_ABS_B, S_CMP, S_T1, S_T2, S_MAX, S_DONE
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ABS  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    state_t       state_q, state_d;
    logic [MSB:0] ra_q, ra_d;
    logic [MSB:0] rb_q, rb_d;
    logic [MSB:0] t_q, t_d;
    logic [MSB:0] result_q, result_d;
    logic         sat_q, sat_d;

    // Out-of-range words (top two bits differ) saturate to 0x3FFF / 0xC000 so no AU step can overflow.
    function automatic logic [MSB:0] clamp(input logic [MSB:0] v);
        if (v[MSB] != v[MSB-1]) begin
            clamp = {v[MSB], v[MSB], {(MSB-1){~v[MSB]}}};
        end else begin
            clamp = v;
        end
    endfunction

    logic ovf_a, ovf_b;
    assign ovf_a = a_i[MSB] ^ a_i[MSB-1];
    assign ovf_b = b_i[MSB] ^ b_i[MSB-1];

    always_comb begin
        // NOTE: every output and next-state signal gets a default first so no branch infers a latch.
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        t_d       = t_q;
        result_d  = result_q;
        sat_d     = sat_q;
        au_in1_o  = '0;
        au_in2_o  = '0;
        au_ctrl_o = OP_PASS;
        done_o    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ra_d     = clamp(a_i);
                    rb_d     = clamp(b_i);
                    sat_d    = ovf_a | ovf_b;
                    result_d = '0;
                    state_d  = S_ABS_A;
                end
            end
            S_ABS_A: begin
                au_ctrl_o = OP_ABS;
                au_in1_o  = ra_q;
                ra_d      = au_out_i;
                state_d   = S_ABS_B;
            end
            S_ABS_B: begin
                au_ctrl_o = OP_ABS;
                au_in1_o  = rb_q;
                rb_d      = au_out_i;
                state_d   = S_CMP;
            end
            S_CMP: begin
                // After this step ra holds x and rb holds y; a tie keeps |a| as x.
                au_ctrl_o = OP_SUB;
                au_in1_o  = ra_q;
                au_in2_o  = rb_q;
                if (au_out_i[MSB]) begin
                    ra_d = rb_q;
                    rb_d = ra_q;
                end
                state_d = S_T1;
            end
            S_T1: begin
                au_ctrl_o = OP_SUB;
                au_in1_o  = ra_q;
                au_in2_o  = {{3{ra_q[MSB]}}, ra_q[MSB:3]};
                t_d       = au_out_i;
                state_d   = S_T2;
            end
            S_T2: begin
                au_ctrl_o = OP_ADD;
                au_in1_o  = t_q;
                au_in2_o  = {rb_q[MSB], rb_q[MSB:1]};
                t_d       = au_out_i;
                state_d   = S_MAX;
            end
            S_MAX: begin
                au_ctrl_o = OP_SUB;
                au_in1_o  = t_q;
                au_in2_o  = ra_q;
                result_d  = au_out_i[MSB] ? ra_q : t_q;
                state_d   = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            t_q      <= '0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all of them update together at the edge.
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            t_q      <= t_d;
            result_q <= result_d;
            sat_q    <= sat_d;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign result_o = result_q;
    assign sat_o    = sat_q;

endmodule

// File: tb/tb_sra_seq_ctrl.sv
// Directed bench for sra_seq_ctrl: a combinational AU model drives au_out, and a job-level
// reference model is compared against every output on every cycle.
module tb_sra_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [15:0] au_in1, au_in2, au_out, result;
    logic [1:0]  au_ctrl;
    logic        busy, done, sat;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sra_seq_ctrl #(.MSB(15)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .a_i       (a),
        .b_i       (b),
        .au_in1_o  (au_in1),
        .au_in2_o  (au_in2),
        .au_ctrl_o (au_ctrl),
        .au_out_i  (au_out),
        .busy_o    (busy),
        .done_o    (done),
        .result_o  (result),
        .sat_o     (sat)
    );

    // External arithmetic unit
    always_comb begin
        case (au_ctrl)
            2'b00:   au_out = au_in1 + au_in2;
            2'b01:   au_out = au_in1 - au_in2;
            2'b10:   au_out = au_in1[15] ? (16'd0 - au_in1) : au_in1;
            default: au_out = au_in1;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v);
        if (v > 16383) return 16383;
        if (v < -16384) return -16384;
        return v;
    endfunction

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference model: phase = number of edges since capture (0 = idle, 7 = done cycle)
    int m_phase = 0;
    int m_ra = 0;
    int m_rb = 0;
    int m_res = 0;
    bit m_sat = 1'b0;
    bit m_ready = 1'b0;

    function automatic int est_x(input int ra, input int rb);
        return (absi(ra) >= absi(rb)) ? absi(ra) : absi(rb);
    endfunction

    function automatic int est_y(input int ra, input int rb);
        return (absi(ra) >= absi(rb)) ? absi(rb) : absi(ra);
    endfunction

    function automatic int est_t(input int ra, input int rb);
        return est_x(ra, rb) - est_x(ra, rb) / 8 + est_y(ra, rb) / 2;
    endfunction

    function automatic int est_mag(input int ra, input int rb);
        return (est_t(ra, rb) < est_x(ra, rb)) ? est_x(ra, rb) : est_t(ra, rb);
    endfunction

    always @(posedge clk) begin
        m_ready <= 1'b1;
        if (rst) begin
            m_phase <= 0;
            m_ra    <= 0;
            m_rb    <= 0;
            m_res   <= 0;
            m_sat   <= 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_ra    <= clampi(int'($signed(a)));
                m_rb    <= clampi(int'($signed(b)));
                m_sat   <= (clampi(int'($signed(a))) != int'($signed(a))) ||
                           (clampi(int'($signed(b))) != int'($signed(b)));
                m_res   <= 0;
                m_phase <= 1;
            end
        end else begin
            m_phase <= (m_phase == 7) ? 0 : m_phase + 1;
            if (m_phase == 6) m_res <= est_mag(m_ra, m_rb);
        end
    end

    int e_in1, e_in2, e_ctrl;
    bit chk_in1, chk_in2;

    initial begin
        forever begin
            @(negedge clk);
            if (m_ready) begin
                e_in1 = 0; e_in2 = 0; e_ctrl = 3; chk_in1 = 1'b1; chk_in2 = 1'b1;
                case (m_phase)
                    1: begin e_ctrl = 2; e_in1 = m_ra; chk_in2 = 1'b0; end
                    2: begin e_ctrl = 2; e_in1 = m_rb; chk_in2 = 1'b0; end
                    3: begin e_ctrl = 1; e_in1 = absi(m_ra); e_in2 = absi(m_rb); end
                    4: begin e_ctrl = 1; e_in1 = est_x(m_ra, m_rb); e_in2 = est_x(m_ra, m_rb) / 8; end
                    5: begin
                        e_ctrl = 0;
                        e_in1  = est_x(m_ra, m_rb) - est_x(m_ra, m_rb) / 8;
                        e_in2  = est_y(m_ra, m_rb) / 2;
                    end
                    6: begin e_ctrl = 1; e_in1 = est_t(m_ra, m_rb); e_in2 = est_x(m_ra, m_rb); end
                    default: ;
                endcase
                check("busy", int'(busy), int'(m_phase != 0));
                check("done", int'(done), int'(m_phase == 7));
                check("result", int'($signed(result)), m_res);
                check("sat", int'(sat), int'(m_sat));
                check("au_ctrl", int'(au_ctrl), e_ctrl);
                if (chk_in1) check("au_in1", int'($signed(au_in1)), e_in1);
                if (chk_in2) check("au_in2", int'($signed(au_in2)), e_in2);
            end
        end
    end

    int ctrl_log [0:31];

    task automatic start_job(input int av, input int bv);
        @(negedge clk);
        a = 16'(av);
        b = 16'(bv);
        start = 1'b1;
    endtask

    // Counts cycles after the capture edge until done; operands are scrambled meanwhile.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            ctrl_log[n] = int'(au_ctrl);
            start = 1'b0;
            a = 16'($urandom);
            b = 16'($urandom);
        end while (!done && n < 20);
        if (!done) check("done_timeout", 0, 1);
    endtask

    int n;
    int dcount;
    int d_idx [0:3];
    int d_res [0:3];

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_ctrl", int'(au_ctrl), 3);
        rst = 1'b0;

        // 3,4 -> 5 with 7-cycle latency
        start_job(3, 4);
        wait_done(n);
        check("t1_latency", n, 7);
        check("t1_result", int'(result), 5);
        check("t1_sat", int'(sat), 0);

        // -100,55 -> 115 with the AU op sequence 10,10,01,01,00,01
        start_job(-100, 55);
        wait_done(n);
        check("t2_ctrl_seq",
              (ctrl_log[1] << 10) | (ctrl_log[2] << 8) | (ctrl_log[3] << 6) |
              (ctrl_log[4] << 4) | (ctrl_log[5] << 2) | ctrl_log[6],
              12'b10_10_01_01_00_01);
        check("t2_result", int'(result), 115);
        check("t2_sat", int'(sat), 0);

        // MAX step picks x
        start_job(1000, 0);
        wait_done(n);
        check("t3_result", int'(result), 1000);

        start_job(0, 0);
        wait_done(n);
        check("t3_zero", int'(result), 0);

        // Clamping
        start_job(-32768, 20000);
        wait_done(n);
        check("t4_result", int'(result), 22527);
        check("t4_sat", int'(sat), 1);

        // start held high: captures only at IDLE edges, one done per 8 cycles
        dcount = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (done) begin
                if (dcount < 4) begin
                    d_idx[dcount] = i;
                    d_res[dcount] = int'(result);
                end
                dcount++;
            end
            start = 1'b1;
            a = (i == 8) ? 16'd6 : 16'(1000 + i);
            b = (i == 8) ? 16'd8 : 16'd0;
        end
        check("t5_done_count", dcount, 2);
        check("t5_first_done", d_idx[0], 7);
        check("t5_second_done", d_idx[1], 15);
        check("t5_first_result", d_res[0], 1000);
        check("t5_second_result", d_res[1], 10);
        wait_done(n);
        check("t5_third_latency", n, 7);
        check("t5_third_result", int'(result), 1016);

        // Reset during T2 discards the job
        start_job(30000, 5);
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("t6_in_t2", int'(au_ctrl), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", int'(busy), 0);
        check("t6_done", int'(done), 0);
        check("t6_result", int'(result), 0);
        check("t6_sat", int'(sat), 0);
        dcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("t6_no_done", dcount, 0);
        start_job(-7, 24);
        wait_done(n);
        check("t6_latency", n, 7);
        check("t6_new_result", int'(result), 24);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
